id_exe_elastic_reg: RTL and testbench

//  Parametrised ID->EXE pipeline register that replaces the fixed single-entry stage register.
//  - Holds up to DEPTH decoded instructions in a circular buffer.
//  - Uses a valid/ready handshake on both sides, so EXE back-pressure does not stall decode.
//  - Supports flush on branch-taken and bubble insertion on hazard.
//  - Sits between the ID decode logic and the EXE stage.

---
 rtl/id_exe_elastic_reg.sv | 102 ++++++++++
 tb/tb_id_exe_elastic_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_elastic_reg.sv
// ID->EXE elastic pipeline register: DEPTH-entry circular buffer with valid/ready on both sides.
// Optional performance counters (bubble/stall) are enabled by defining ID_EXE_PERF_CNT_EN.
module id_exe_elastic_reg #(
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned DATA_W = 172,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         hazard,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             bubble_cnt,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Handshake flags derive from registered state only; no out_ready -> in_ready path.
    assign in_ready  = (count < OCC_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];
    assign out_ctrl  = out_valid ? head.ctrl : '0;
    assign out_data  = head.data;
    assign occupancy = count;

    // Pointer/count state; flush outranks push and pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage; a hazard turns the entry into a bubble by zeroing its control bits.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= '{ctrl: (hazard ? '0 : in_ctrl), data: in_data};
        end
    end

`ifdef ID_EXE_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] stall_q;

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
            stall_q  <= '0;
        end else begin
            if (push && hazard && (bubble_q != '1))    bubble_q <= bubble_q + 1'b1;
            if (in_valid && !in_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
        end
    end

    assign bubble_cnt = bubble_q;
    assign stall_cnt  = stall_q;
`else
    assign bubble_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_exe_elastic_reg.sv
// Bench for id_exe_elastic_reg: queue-based reference model checked every cycle plus directed literal checks.
module tb_id_exe_elastic_reg;

    localparam int unsigned CTRL_W = 10;
    localparam int unsigned DATA_W = 172;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              hazard = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    id_exe_elastic_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hazard(hazard),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a plain FIFO of {ctrl,data} plus saturating counters.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t             q[$];
    logic [CNT_W-1:0] m_bub = '0;
    logic [CNT_W-1:0] m_stl = '0;
    bit               live = 0;

    always @(posedge clk) begin
        bit rdy;
        bit do_pop;
        bit do_push;
        if (rst) begin
            q.delete();
            m_bub = '0;
            m_stl = '0;
        end else begin
            rdy     = (q.size() < DEPTH);
            do_push = in_valid && rdy;
            do_pop  = (q.size() != 0) && out_ready;
            if (in_valid && !rdy && m_stl != '1) m_stl = m_stl + 1'b1;
            if (do_push && hazard && m_bub != '1) m_bub = m_bub + 1'b1;
            if (flush) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{ctrl: (hazard ? '0 : in_ctrl), data: in_data});
            end
        end
        live = 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            chk("m_occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
            chk("m_out_valid", DATA_W'(out_valid), DATA_W'(q.size() != 0));
            chk("m_in_ready",  DATA_W'(in_ready),  DATA_W'(q.size() < DEPTH));
            chk("m_out_ctrl",  DATA_W'(out_ctrl),  (q.size() != 0) ? DATA_W'(q[0].ctrl) : '0);
            if (q.size() != 0) chk("m_out_data", out_data, q[0].data);
`ifdef ID_EXE_PERF_CNT_EN
            chk("m_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bub));
            chk("m_stall_cnt",  DATA_W'(stall_cnt),  DATA_W'(m_stl));
`else
            chk("m_bubble_cnt", DATA_W'(bubble_cnt), '0);
            chk("m_stall_cnt",  DATA_W'(stall_cnt),  '0);
`endif
        end
    end

    function automatic logic [DATA_W-1:0] pat(input logic [3:0] n);
        return DATA_W'({43{n}});
    endfunction

    // Apply inputs, then advance through one rising edge to the next falling edge.
    task automatic step(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic hz, input logic ordy, input logic fl);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        hazard    = hz;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, ordy, 1'b0);
    endtask

    logic [CNT_W-1:0] exp_bub;
    logic [CNT_W-1:0] exp_stl;

    initial begin
        // 1. Reset held for two cycles
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_out_valid", DATA_W'(out_valid), '0);
        chk("rst_out_ctrl",  DATA_W'(out_ctrl),  '0);
        chk("rst_in_ready",  DATA_W'(in_ready),  DATA_W'(1));
        chk("rst_occupancy", DATA_W'(occupancy), '0);
        rst = 1'b0;

        // 2. Fill with out_ready low, then drain in order
        step(1'b1, 10'h3A5, pat(4'hA), 1'b0, 1'b0, 1'b0);
        chk("push_latency_valid", DATA_W'(out_valid), DATA_W'(1));
        step(1'b1, 10'h011, pat(4'hB), 1'b0, 1'b0, 1'b0);
        chk("fill_occupancy", DATA_W'(occupancy), DATA_W'(2));
        chk("fill_in_ready",  DATA_W'(in_ready),  '0);
        chk("fill_head_ctrl", DATA_W'(out_ctrl),  DATA_W'(10'h3A5));
        chk("fill_head_data", out_data, pat(4'hA));
        idle(1'b1);
        chk("drain1_ctrl", DATA_W'(out_ctrl), DATA_W'(10'h011));
        chk("drain1_data", out_data, pat(4'hB));
        idle(1'b1);
        chk("drain2_occupancy", DATA_W'(occupancy), '0);

        // 3. Full with simultaneous pop: push refused, accepted next cycle
        step(1'b1, 10'h3A5, pat(4'hA), 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h011, pat(4'hB), 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h0C3, pat(4'hC), 1'b0, 1'b1, 1'b0);
        chk("full_pop_occupancy", DATA_W'(occupancy), DATA_W'(1));
        chk("full_pop_in_ready",  DATA_W'(in_ready),  DATA_W'(1));
        chk("full_pop_head",      DATA_W'(out_ctrl),  DATA_W'(10'h011));
        step(1'b1, 10'h0C3, pat(4'hC), 1'b0, 1'b0, 1'b0);
        chk("c_accepted_occ", DATA_W'(occupancy), DATA_W'(2));
        idle(1'b1);
        chk("c_head_ctrl", DATA_W'(out_ctrl), DATA_W'(10'h0C3));
        chk("c_head_data", out_data, pat(4'hC));
        idle(1'b1);

        // 4. Hazard writes a bubble
        step(1'b1, 10'h3FF, pat(4'h5), 1'b1, 1'b0, 1'b0);
        chk("bubble_valid", DATA_W'(out_valid), DATA_W'(1));
        chk("bubble_ctrl",  DATA_W'(out_ctrl),  '0);
        chk("bubble_data",  out_data, pat(4'h5));
        idle(1'b1);
        chk("bubble_popped", DATA_W'(occupancy), '0);

        // 5. Flush collides with push and pop
        step(1'b1, 10'h111, pat(4'h1), 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h222, pat(4'h2), 1'b0, 1'b1, 1'b1);
        chk("flush_occupancy", DATA_W'(occupancy), '0);
        chk("flush_out_valid", DATA_W'(out_valid), '0);
        idle(1'b1);
        idle(1'b1);
        chk("flush_no_ghost", DATA_W'(out_valid), '0);

        // 6. Performance counters: 3 bubbles, 5 stalls, survive flush, cleared by reset
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 10'h3FF, pat(4'(i + 6)), 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        step(1'b1, 10'h001, pat(4'h9), 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h002, pat(4'hD), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 10'h003, pat(4'hE), 1'b0, 1'b0, 1'b0);
`ifdef ID_EXE_PERF_CNT_EN
        exp_bub = CNT_W'(3);
        exp_stl = CNT_W'(5);
`else
        exp_bub = '0;
        exp_stl = '0;
`endif
        chk("perf_bubble", DATA_W'(bubble_cnt), DATA_W'(exp_bub));
        chk("perf_stall",  DATA_W'(stall_cnt),  DATA_W'(exp_stl));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("perf_flush_bubble", DATA_W'(bubble_cnt), DATA_W'(exp_bub));
        chk("perf_flush_stall",  DATA_W'(stall_cnt),  DATA_W'(exp_stl));
        chk("perf_flush_occ",    DATA_W'(occupancy),  '0);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        chk("perf_rst_bubble", DATA_W'(bubble_cnt), '0);
        chk("perf_rst_stall",  DATA_W'(stall_cnt),  '0);

        idle(1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
